// File: rtl/pe_split.sv
// pe_split: one-to-two data splitter for the PE datapath.
//
// Pairs one data token from L with one select token from S and pushes the
// data into the output FIFO chosen by the select (0 -> R0, 1 -> R1). Each
// output owns a DEPTH-entry FIFO, so a stalled consumer only blocks tokens
// headed to its own side once that FIFO is full.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   l_data/l_valid/l_ready input data token handshake
//   s_sel/s_valid/s_ready  select token handshake (joined with L)
//   r0_* / r1_*            output FIFO heads with valid/ready handshake
//   cnt0 / cnt1            tokens accepted for R0 / R1 since reset (wrapping)
module pe_split #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] l_data,
    input  logic             l_valid,
    output logic             l_ready,
    input  logic             s_sel,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] r0_data,
    output logic             r0_valid,
    input  logic             r0_ready,
    output logic [WIDTH-1:0] r1_data,
    output logic             r1_valid,
    input  logic             r1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                  accept;
    logic [1:0]            full;
    logic [1:0]            nonempty;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            rdy;
    logic [1:0][WIDTH-1:0] head;
    logic [1:0][CNT_W-1:0] cnt;

    assign rdy = {r1_ready, r0_ready};

    // Join: both tokens are taken together, only when the target FIFO has
    // room according to its registered occupancy (no same-cycle slot reuse).
    assign accept  = ~reset & l_valid & s_valid & ~full[s_sel];
    assign l_ready = accept;
    assign s_ready = accept;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [OCC_W-1:0] occ;
        logic [CNT_W-1:0] cnt_r;

        assign full[g]     = (occ == OCC_W'(DEPTH));
        assign nonempty[g] = (occ != '0);
        assign push[g]     = accept & (s_sel == 1'(g));
        assign pop[g]      = nonempty[g] & rdy[g];
        // Storage is not reset; the head is forced to zero while empty so
        // stale entries never leak out after a reset.
        assign head[g]     = nonempty[g] ? mem[rd_ptr] : '0;
        assign cnt[g]      = cnt_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                cnt_r  <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    cnt_r  <= cnt_r + CNT_W'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push[g], pop[g]})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr] <= l_data;
            end
        end
    end

    assign r0_data  = head[0];
    assign r1_data  = head[1];
    assign r0_valid = nonempty[0];
    assign r1_valid = nonempty[1];
    assign cnt0     = cnt[0];
    assign cnt1     = cnt[1];

endmodule

// File: tb/tb_pe_split.sv
module tb_pe_split;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CMOD  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] l_data;
    logic             l_valid;
    logic             l_ready;
    logic             s_sel;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] r0_data;
    logic             r0_valid;
    logic             r0_ready;
    logic [WIDTH-1:0] r1_data;
    logic             r1_valid;
    logic             r1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    pe_split #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .l_data(l_data), .l_valid(l_valid), .l_ready(l_ready),
        .s_sel(s_sel), .s_valid(s_valid), .s_ready(s_ready),
        .r0_data(r0_data), .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r1_data(r1_data), .r1_valid(r1_valid), .r1_ready(r1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per output, counters as plain integers.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] got0[$];
    logic [WIDTH-1:0] got1[$];
    int mc0 = 0;
    int mc1 = 0;
    int passed = 0;
    int total = 0;

    function automatic bit m_accept();
        bit tgt_full;
        tgt_full = s_sel ? (q1.size() == DEPTH) : (q0.size() == DEPTH);
        return !reset && l_valid && s_valid && !tgt_full;
    endfunction

    // Advance the model by one clock using the inputs currently driven,
    // then move the DUT across the same rising edge.
    task automatic tick();
        bit acc;
        acc = m_accept();
        if (reset) begin
            q0.delete(); q1.delete();
            mc0 = 0; mc1 = 0;
        end else begin
            if (r0_ready && q0.size() > 0) got0.push_back(q0.pop_front());
            if (r1_ready && q1.size() > 0) got1.push_back(q1.pop_front());
            if (acc) begin
                if (s_sel) begin q1.push_back(l_data); mc1 = (mc1 + 1) % CMOD; end
                else       begin q0.push_back(l_data); mc0 = (mc0 + 1) % CMOD; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic sv, input logic sel, input logic [WIDTH-1:0] d);
        l_valid = lv; s_valid = sv; s_sel = sel; l_data = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; r0_ready = 1'b0; r1_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h11);
        tick(); tick();
        @(negedge clk);
        total++; if (l_ready !== 1'b0) $display("FAIL reset_l_ready: got %b expected 0", l_ready); else passed++;
        total++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b expected 0", s_ready); else passed++;
        total++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) $display("FAIL reset_valids: got %b%b expected 00", r1_valid, r0_valid); else passed++;
        total++; if (r0_data !== 8'h00 || r1_data !== 8'h00) $display("FAIL reset_data: got %h/%h expected 00/00", r0_data, r1_data); else passed++;
        total++; if (cnt0 !== '0 || cnt1 !== '0) $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); else passed++;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_basic_route();
        r0_ready = 1'b1; r1_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h3C);
        @(negedge clk);
        total++; if (l_ready !== 1'b1) $display("FAIL route_accept0: got %b expected 1", l_ready); else passed++;
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'hA5);
        @(negedge clk);
        total++; if (r0_valid !== 1'b1 || r0_data !== 8'h3C) $display("FAIL route_r0: got %b/%h expected 1/3c", r0_valid, r0_data); else passed++;
        total++; if (s_ready !== 1'b1) $display("FAIL route_accept1: got %b expected 1", s_ready); else passed++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        total++; if (r1_valid !== 1'b1 || r1_data !== 8'hA5) $display("FAIL route_r1: got %b/%h expected 1/a5", r1_valid, r1_data); else passed++;
        total++; if (r0_valid !== 1'b0) $display("FAIL route_r0_popped: got %b expected 0", r0_valid); else passed++;
        total++; if (cnt0 !== 4'd1 || cnt1 !== 4'd1) $display("FAIL route_cnt: got %0d/%0d expected 1/1", cnt0, cnt1); else passed++;
        tick();
    endtask

    task automatic test_join_hold();
        r1_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (l_ready !== 1'b0 || r1_valid !== 1'b0) $display("FAIL join_hold_%0d: got ready %b valid %b expected 0 0", i, l_ready, r1_valid); else passed++;
            tick();
        end
        s_valid = 1'b1;
        @(negedge clk);
        total++; if (s_ready !== 1'b1 || l_ready !== 1'b1) $display("FAIL join_accept: got %b%b expected 11", s_ready, l_ready); else passed++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        total++; if (r1_valid !== 1'b1 || r1_data !== 8'h5A) $display("FAIL join_out: got %b/%h expected 1/5a", r1_valid, r1_data); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int acc_cycle;
        r0_ready = 1'b0; r1_ready = 1'b1;
        got0.delete(); got1.delete();
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, WIDTH'(i));
            @(negedge clk);
            total++; if (l_ready !== 1'b1) $display("FAIL bp_fill_%0d: got %b expected 1", i, l_ready); else passed++;
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 8'h03);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (l_ready !== 1'b0 || r0_data !== 8'h01) $display("FAIL bp_stall_%0d: got ready %b head %h expected 0 01", i, l_ready, r0_data); else passed++;
            tick();
        end
        r0_ready = 1'b1;
        acc_cycle = -1;
        for (int i = 0; i < 4 && acc_cycle < 0; i++) begin
            @(negedge clk);
            if (l_ready === 1'b1) acc_cycle = i;
            tick();
        end
        total++; if (acc_cycle != 1) $display("FAIL bp_release: accepted in cycle %0d expected 1", acc_cycle); else passed++;
        drive(1'b1, 1'b1, 1'b1, 8'h77);
        @(negedge clk);
        total++; if (s_ready !== 1'b1) $display("FAIL bp_r1_accept: got %b expected 1", s_ready); else passed++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick();
        end
        total++;
        if (got0.size() != 3 || got0[0] !== 8'h01 || got0[1] !== 8'h02 || got0[2] !== 8'h03)
            $display("FAIL bp_order: got %0d tokens on r0 expected 01 02 03", got0.size());
        else passed++;
        total++; if (got1.size() != 1 || got1[0] !== 8'h77) $display("FAIL bp_r1_token: got %0d tokens expected one 77", got1.size()); else passed++;
    endtask

    task automatic test_full_pop();
        r0_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'hAA); tick();
        drive(1'b1, 1'b1, 1'b0, 8'hBB); tick();
        drive(1'b1, 1'b1, 1'b0, 8'hCC);
        r0_ready = 1'b1;
        @(negedge clk);
        total++; if (l_ready !== 1'b0 || r0_data !== 8'hAA) $display("FAIL fp_refuse: got ready %b head %h expected 0 aa", l_ready, r0_data); else passed++;
        tick();
        r0_ready = 1'b0;
        @(negedge clk);
        total++; if (l_ready !== 1'b1 || r0_data !== 8'hBB) $display("FAIL fp_accept: got ready %b head %h expected 1 bb", l_ready, r0_data); else passed++;
        tick();
        @(negedge clk);
        total++; if (l_ready !== 1'b0 || r0_data !== 8'hBB) $display("FAIL fp_full_again: got ready %b head %h expected 0 bb", l_ready, r0_data); else passed++;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        r0_ready = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        total++; if (r0_valid !== 1'b0) $display("FAIL fp_drained: got %b expected 0", r0_valid); else passed++;
        tick();
    endtask

    task automatic test_counter_wrap();
        reset = 1'b1; tick(); reset = 1'b0;
        r1_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 1'b1, WIDTH'(i + 8'h40));
            @(negedge clk);
            total++; if (l_ready !== 1'b1) $display("FAIL wrap_b2b_%0d: got %b expected 1", i, l_ready); else passed++;
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        total++; if (cnt1 !== 4'd1 || cnt0 !== 4'd0) $display("FAIL wrap_cnt: got %0d/%0d expected 0/1", cnt0, cnt1); else passed++;
        total++; if (cnt1 !== CNT_W'(mc1)) $display("FAIL wrap_model: got %0d expected %0d", cnt1, mc1); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        r0_ready = 1'b0; r1_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h21); tick();
        drive(1'b1, 1'b1, 1'b0, 8'h22); tick();
        drive(1'b1, 1'b1, 1'b1, 8'h31); tick();
        drive(1'b1, 1'b1, 1'b1, 8'h44);
        reset = 1'b1;
        @(negedge clk);
        total++; if (r0_valid !== 1'b1 || r1_valid !== 1'b1) $display("FAIL rm_loaded: got %b%b expected 11", r1_valid, r0_valid); else passed++;
        total++; if (l_ready !== 1'b0 || s_ready !== 1'b0) $display("FAIL rm_ready_in_reset: got %b%b expected 00", l_ready, s_ready); else passed++;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        total++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) $display("FAIL rm_valids: got %b%b expected 00", r1_valid, r0_valid); else passed++;
        total++; if (cnt0 !== '0 || cnt1 !== '0) $display("FAIL rm_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); else passed++;
        drive(1'b1, 1'b1, 1'b0, 8'h9E);
        r0_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        total++; if (r0_valid !== 1'b1 || r0_data !== 8'h9E) $display("FAIL rm_new: got %b/%h expected 1/9e", r0_valid, r0_data); else passed++;
        tick();
        @(negedge clk);
        total++; if (r0_valid !== 1'b0 || r1_valid !== 1'b0) $display("FAIL rm_no_stale: got %b%b expected 00", r1_valid, r0_valid); else passed++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), WIDTH'($urandom));
            r0_ready = ($urandom_range(0, 9) < 6);
            r1_ready = ($urandom_range(0, 9) < 4);
            @(negedge clk);
            total++; if (l_ready !== m_accept() || s_ready !== m_accept()) $display("FAIL rnd_ready_%0d: got %b%b expected %b", i, l_ready, s_ready, m_accept()); else passed++;
            total++; if (r0_valid !== (q0.size() != 0) || r0_data !== (q0.size() != 0 ? q0[0] : 8'h00)) $display("FAIL rnd_r0_%0d: got %b/%h expected %b/%h", i, r0_valid, r0_data, q0.size() != 0, q0.size() != 0 ? q0[0] : 8'h00); else passed++;
            total++; if (r1_valid !== (q1.size() != 0) || r1_data !== (q1.size() != 0 ? q1[0] : 8'h00)) $display("FAIL rnd_r1_%0d: got %b/%h expected %b/%h", i, r1_valid, r1_data, q1.size() != 0, q1.size() != 0 ? q1[0] : 8'h00); else passed++;
            total++; if (cnt0 !== CNT_W'(mc0) || cnt1 !== CNT_W'(mc1)) $display("FAIL rnd_cnt_%0d: got %0d/%0d expected %0d/%0d", i, cnt0, cnt1, mc0, mc1); else passed++;
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_join_hold();
        test_backpressure();
        test_full_pop();
        test_counter_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pe_split.md
# pe_split

Clocked one-to-two data splitter for the PE datapath, the steering counterpart of the PE merge. It pairs one data token from `L` with one select token from `S` and routes the data to `R0` (select 0) or `R1` (select 1). Each output has its own small FIFO, so a stalled consumer on one side does not block tokens headed to the other side until that side's FIFO fills. Per-output token counters support debug and scoreboard checks.

## Interface
- `WIDTH`, 8, data token width in bits.
- `DEPTH`, 2, entries per output FIFO; power of two, ≥ 2.
- `CNT_W`, 16, width of each routed-token counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `l_data`  in  WIDTH  input data token.
- `l_valid`  in  1  `l_data` is valid.
- `l_ready`  out  1  input data accepted this cycle.
- `s_sel`  in  1  select token: 0 routes to R0, 1 routes to R1.
- `s_valid`  in  1  `s_sel` is valid.
- `s_ready`  out  1  select accepted this cycle.
- `r0_data`, `r1_data`  out  WIDTH  head entry of each output FIFO.
- `r0_valid`, `r1_valid`  out  1  output FIFO is non-empty.
- `r0_ready`, `r1_ready`  in  1  consumer takes the head entry this cycle.
- `cnt0`, `cnt1`  out  CNT_W  tokens accepted for R0 and R1 since reset.

## Operation
- Join rule: `accept = l_valid & s_valid & ~full[s_sel]`.
- `l_ready = s_ready = accept`. These are combinational and depend on the valids. Neither input is consumed without the other.
- On accept, `l_data` is pushed into FIFO[`s_sel`] and `cnt[s_sel]` increments.
- Counters wrap modulo 2^CNT_W: 0xFFFF + 1 → 0x0000.
- Pop: `rN_valid & rN_ready` removes the head of FIFO N.
- `full`/`empty` come from the registered occupancy count (0..DEPTH) of each FIFO.
- A full FIFO blocks a push even when it is popped in the same cycle. There is no same-cycle slot reuse.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged, and the head advances while the tail appends.
- Push to an empty FIFO while `rN_ready` = 1: the token is not output that cycle. It becomes visible the next cycle.
- The two FIFOs are independent. A full R0 blocks only select-0 tokens. A pending select-1 pair is still accepted.
- Input order is preserved per output. There is no ordering relationship between R0 and R1.
- `rN_valid` and `rN_data` must stay stable while `rN_ready` = 0.
- Reset mid-operation: all FIFO contents are discarded, with no drain.

## Timing
- Latency from accept to `rN_valid` = 1 cycle.
- Throughput is 1 token/cycle aggregate, while the target FIFO is not full.
- Reset values: `r0_valid` = `r1_valid` = 0, `r0_data` = `r1_data` = 0, `cnt0` = `cnt1` = 0, all pointers and occupancy = 0.
- `l_ready` and `s_ready` are 0 whenever `reset` is high, regardless of the valids.
- Reset takes priority over push and pop in the same cycle.
- First accept is possible in the cycle after `reset` deasserts.
- Pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH and never goes below 0.

## Test plan
- Basic route: `l_data`=0x3C with `s_sel`=0, then 0xA5 with `s_sel`=1, both consumers ready → `r0_data`=0x3C one cycle after its accept, `r1_data`=0xA5 one cycle after its accept; `cnt0`=1, `cnt1`=1.
- Join hold: `l_valid`=1 for 5 cycles with `s_valid`=0 → `l_ready`=0 throughout and no output. Raise `s_valid` with `s_sel`=1 → accepted that cycle; `r1_valid`=1 next cycle.
- Backpressure isolation (DEPTH=2): `r0_ready`=0, send 0x01, 0x02, 0x03 to R0 → first two accepted, third stalls (`l_ready`=0). Then a select-1 pair (0x77) → still stalls, because the inputs are in order and the head pair targets R0. Raise `r0_ready` → 0x01, 0x02, 0x03 delivered in order, then 0x77 goes to R1.
- Full plus pop same cycle: R0 full with `r0_ready`=1 and a select-0 pair pending → pop occurs, push is refused that cycle, push is accepted next cycle; occupancy sequence 2→1→2.
- Counter wrap (CNT_W=4 build): route 17 tokens to R1 → `cnt1`=1, `cnt0`=0.
- Reset mid-stream: R0 holds 2 tokens and R1 holds 1 token; assert `reset` for 1 cycle → next cycle all valids are 0, both counters are 0, and no stale data appears after new traffic starts.
